// File: rtl/mdu_sequencer.sv
// mdu_sequencer
// Iterative RV32M multiply/divide unit that sits next to the EX-stage ALU.
// Each accepted operation runs a radix-2 loop, one bit per cycle: shift-add
// for multiplies and restoring division for divides. The result is registered
// and the pipeline is held while the unit works.
//
// Ports
//   i_Clock   : clock, rising edge
//   i_Reset   : asynchronous reset, active low
//   i_start   : request a new operation (sampled only in IDLE)
//   i_op      : 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//               100 DIV, 101 DIVU, 110 REM,    111 REMU
//   i_dataA   : rs1 (multiplicand / dividend)
//   i_dataB   : rs2 (multiplier / divisor)
//   i_flush   : abort the operation in flight; its result is discarded
//   o_busy    : unit is not idle
//   o_stall   : hold request to the EX stage
//   o_valid   : one-cycle pulse, o_result carries a new value
//   o_result  : registered result, held until the next o_valid
//
// State  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for i_start; divide-by-zero/overflow resolve here
// CALC   | one multiply or divide iteration per cycle, WIDTH iterations
// FIXUP  | sign correction and result selection into o_result
// DONE   | o_valid high for this single cycle
module mdu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_dataA,
  input  logic [WIDTH-1:0] i_dataB,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_stall,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q,  state_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [2:0]       op_q,     op_d;
  // hi: upper product half during multiply, WIDTH+1-bit partial remainder
  // during divide. lo: multiplier shifting out / dividend shifting out while
  // quotient bits shift in. opb: multiplicand or divisor magnitude.
  logic [WIDTH:0]   hi_q,     hi_d;
  logic [WIDTH-1:0] lo_q,     lo_d;
  logic [WIDTH-1:0] opb_q,    opb_d;
  logic             neg_q,    neg_d;
  logic [WIDTH-1:0] result_q, result_d;

  // ---------------------------------------------------------------------
  // Acceptance decode (operates on the live inputs in IDLE)
  // ---------------------------------------------------------------------
  logic             a_signed, b_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, div_ovf;
  logic [WIDTH-1:0] special_res;

  always_comb begin
    a_signed = (i_op == OP_MULH) || (i_op == OP_MULHSU) ||
               (i_op == OP_DIV)  || (i_op == OP_REM);
    b_signed = (i_op == OP_MULH) || (i_op == OP_DIV) || (i_op == OP_REM);
    a_neg    = a_signed & i_dataA[WIDTH-1];
    b_neg    = b_signed & i_dataB[WIDTH-1];
    a_mag    = a_neg ? (~i_dataA + 1'b1) : i_dataA;
    b_mag    = b_neg ? (~i_dataB + 1'b1) : i_dataB;

    div_zero = i_op[2] && (i_dataB == '0);
    // Only the signed divides (op[0]=0) can overflow.
    div_ovf  = i_op[2] && !i_op[0] && (i_dataA == INT_MIN) && (i_dataB == '1);

    if (div_zero) begin
      special_res = i_op[1] ? i_dataA : '1;
    end else begin
      special_res = i_op[1] ? '0 : INT_MIN;
    end
  end

  // ---------------------------------------------------------------------
  // One iteration of the loop
  // ---------------------------------------------------------------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH+1:0] div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_ok;

  always_comb begin
    if (lo_q[0]) begin
      mul_sum = {1'b0, hi_q[WIDTH-1:0]} + {1'b0, opb_q};
    end else begin
      mul_sum = {1'b0, hi_q[WIDTH-1:0]};
    end

    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {2'b00, opb_q};
    // No borrow out of the trial subtraction means the quotient bit is 1.
    div_ok    = !div_diff[WIDTH+1];
  end

  // ---------------------------------------------------------------------
  // Sign correction and result selection
  // ---------------------------------------------------------------------
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_res;

  always_comb begin
    product  = {hi_q[WIDTH-1:0], lo_q};
    prod_fix = neg_q ? (~product + 1'b1) : product;
    quot_fix = neg_q ? (~lo_q + 1'b1) : lo_q;
    rem_fix  = neg_q ? (~hi_q[WIDTH-1:0] + 1'b1) : hi_q[WIDTH-1:0];

    case (op_q)
      OP_MUL:                       fix_res = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              fix_res = quot_fix;
      default:                      fix_res = rem_fix;
    endcase
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    result_d = result_q;

    if (i_flush) begin
      // Abort from any state; o_result is deliberately left untouched.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            op_d  = i_op;
            // Remainder follows the dividend; product/quotient the XOR.
            neg_d = (i_op == OP_REM) ? a_neg : (a_neg ^ b_neg);
            if (div_zero || div_ovf) begin
              result_d = special_res;
              state_d  = S_DONE;
            end else begin
              hi_d    = '0;
              lo_d    = i_op[2] ? a_mag : b_mag;
              opb_d   = i_op[2] ? b_mag : a_mag;
              cnt_d   = CW'(WIDTH - 1);
              state_d = S_CALC;
            end
          end
        end

        S_CALC: begin
          if (op_q[2]) begin
            hi_d = div_ok ? div_diff[WIDTH:0] : div_shift[WIDTH:0];
            lo_d = {lo_q[WIDTH-2:0], div_ok};
          end else begin
            hi_d = {1'b0, mul_sum[WIDTH:1]};
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
          end

          if (cnt_q == '0) begin
            state_d = S_FIXUP;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        S_FIXUP: begin
          result_d = fix_res;
          state_d  = S_DONE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign o_busy   = (state_q != S_IDLE);
  assign o_valid  = (state_q == S_DONE);
  assign o_result = result_q;
  assign o_stall  = ((state_q == S_IDLE) && i_start && !i_flush) ||
                    (state_q == S_CALC) || (state_q == S_FIXUP);

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;

  localparam int W = 32;
  localparam logic [31:0] MIN32 = 32'h8000_0000;

  logic          i_Clock;
  logic          i_Reset;
  logic          i_start;
  logic [2:0]    i_op;
  logic [W-1:0]  i_dataA;
  logic [W-1:0]  i_dataB;
  logic          i_flush;
  logic          o_busy;
  logic          o_stall;
  logic          o_valid;
  logic [W-1:0]  o_result;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_res;

  mdu_sequencer #(.WIDTH(W)) dut (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_start (i_start),
    .i_op    (i_op),
    .i_dataA (i_dataA),
    .i_dataB (i_dataB),
    .i_flush (i_flush),
    .o_busy  (o_busy),
    .o_stall (o_stall),
    .o_valid (o_valid),
    .o_result(o_result)
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model straight from the RV32M definitions, in 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    p  = '0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN32 && b == 32'hFFFF_FFFF) return MIN32;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN32 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2] && (b == 0)) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == MIN32 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Called #1 after a rising edge. Starts one operation, waits for o_valid,
  // checks latency, result, the stall window and the return to idle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat, input string tag);
    int lat;
    bit stall_ok;
    i_start = 1'b1;
    i_op    = op;
    i_dataA = a;
    i_dataB = b;
    @(negedge i_Clock);
    chk($sformatf("%s stall_at_start", tag), {31'b0, o_stall}, 32'd1);
    @(posedge i_Clock); #1;
    i_start  = 1'b0;
    i_op     = 3'($urandom);
    i_dataA  = $urandom;
    i_dataB  = $urandom;
    lat      = 0;
    stall_ok = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge i_Clock);
      if (o_valid) begin
        lat = c;
        break;
      end
      if (!o_stall || !o_busy) stall_ok = 1'b0;
      @(posedge i_Clock); #1;
      i_dataA = $urandom;
      i_dataB = $urandom;
    end
    chk($sformatf("%s latency", tag), 32'(lat), 32'(exp_lat));
    chk($sformatf("%s result", tag), o_result, exp_res);
    chk($sformatf("%s stall_in_done", tag), {31'b0, o_stall}, 32'd0);
    chk($sformatf("%s stall_window", tag), {31'b0, stall_ok}, 32'd1);
    @(posedge i_Clock); #1;
    @(negedge i_Clock);
    chk($sformatf("%s busy_after", tag), {31'b0, o_busy}, 32'd0);
    @(posedge i_Clock); #1;
    last_res = exp_res;
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b, cap;
    int          first_valid, nvalid, r;

    i_Reset = 1'b1;
    i_start = 1'b0;
    i_op    = '0;
    i_dataA = '0;
    i_dataB = '0;
    i_flush = 1'b0;
    last_res = '0;

    vecs[0]  = '{3'd0, 32'd7,          32'd6,          32'h0000_002A, 34};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 34};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 34};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF, 34};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 34};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 34};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,          32'd14,        34};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,          32'd2,         34};
    vecs[8]  = '{3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd6, 32'd5,          32'd0,          32'd5,         1};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 1};
    vecs[12] = '{3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 34};
    vecs[13] = '{3'd4, 32'h8000_0000,  32'd1,          32'h8000_0000, 34};

    #1 i_Reset = 1'b0;
    #2;
    chk("reset busy",   {31'b0, o_busy},  32'd0);
    chk("reset valid",  {31'b0, o_valid}, 32'd0);
    chk("reset stall",  {31'b0, o_stall}, 32'd0);
    chk("reset result", o_result,         32'd0);
    @(negedge i_Clock);
    @(negedge i_Clock);
    i_Reset = 1'b1;
    @(posedge i_Clock); #1;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat,
             $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      r  = $urandom_range(0, 9);
      if (r == 0) b = '0;
      if (r == 1) begin a = MIN32; b = 32'hFFFF_FFFF; end
      if (r == 2) b = 32'($urandom_range(1, 15));
      if (r == 3) a = 32'($urandom_range(0, 200));
      run_op(op, a, b, ref_result(op, a, b), ref_latency(op, a, b),
             $sformatf("rnd%0d op%0d", i, op));
    end

    // Flush at cycle 10 of a MUL, restart at cycle 11.
    i_start = 1'b1; i_op = 3'd0; i_dataA = 32'd1234; i_dataB = 32'd5678;
    first_valid = -1;
    cap = '0;
    for (int c = 0; c <= 50; c++) begin
      if (c == 1)  i_start = 1'b0;
      if (c == 10) i_flush = 1'b1;
      if (c == 11) begin
        i_flush = 1'b0; i_start = 1'b1; i_op = 3'd0; i_dataA = 32'd3; i_dataB = 32'd5;
      end
      if (c == 12) i_start = 1'b0;
      @(negedge i_Clock);
      if (c == 11) begin
        chk("flush idle_next", {31'b0, o_busy}, 32'd0);
        chk("flush result_kept", o_result, last_res);
      end
      if (o_valid && first_valid < 0) begin
        first_valid = c;
        cap = o_result;
      end
      @(posedge i_Clock); #1;
    end
    chk("flush restart_valid_cycle", 32'(first_valid), 32'd45);
    chk("flush restart_result", cap, 32'd15);
    last_res = 32'd15;

    // i_start held through a whole operation with changing operands.
    i_start = 1'b1; i_op = 3'd5; i_dataA = 32'd100; i_dataB = 32'd7;
    nvalid = 0; first_valid = -1;
    for (int c = 0; c <= 40; c++) begin
      if (c >= 1 && c <= 34) begin
        i_op = 3'($urandom); i_dataA = $urandom; i_dataB = $urandom;
      end
      if (c == 35) i_start = 1'b0;
      @(negedge i_Clock);
      if (o_valid) begin
        nvalid++;
        first_valid = c;
        cap = o_result;
      end
      if (c == 36) chk("held busy_after", {31'b0, o_busy}, 32'd0);
      @(posedge i_Clock); #1;
    end
    chk("held valid_count", 32'(nvalid), 32'd1);
    chk("held valid_cycle", 32'(first_valid), 32'd34);
    chk("held result", cap, 32'd14);
    last_res = 32'd14;

    // Start and flush together in IDLE.
    i_start = 1'b1; i_flush = 1'b1; i_op = 3'd5; i_dataA = 32'd100; i_dataB = 32'd7;
    @(negedge i_Clock);
    chk("startflush stall", {31'b0, o_stall}, 32'd0);
    @(posedge i_Clock); #1;
    i_start = 1'b0; i_flush = 1'b0;
    @(negedge i_Clock);
    chk("startflush busy", {31'b0, o_busy}, 32'd0);
    chk("startflush valid", {31'b0, o_valid}, 32'd0);
    @(posedge i_Clock); #1;

    // Flush during DONE: valid still visible that cycle, then idle.
    i_start = 1'b1; i_op = 3'd5; i_dataA = 32'd5; i_dataB = 32'd0;
    @(posedge i_Clock); #1;
    i_start = 1'b0; i_flush = 1'b1;
    @(negedge i_Clock);
    chk("flushdone valid", {31'b0, o_valid}, 32'd1);
    chk("flushdone result", o_result, 32'hFFFF_FFFF);
    @(posedge i_Clock); #1;
    i_flush = 1'b0;
    @(negedge i_Clock);
    chk("flushdone busy", {31'b0, o_busy}, 32'd0);
    chk("flushdone valid_gone", {31'b0, o_valid}, 32'd0);
    @(posedge i_Clock); #1;

    // Reset asserted mid-CALC.
    i_start = 1'b1; i_op = 3'd0; i_dataA = 32'd9; i_dataB = 32'd9;
    @(posedge i_Clock); #1;
    i_start = 1'b0;
    repeat (5) begin @(posedge i_Clock); #1; end
    i_Reset = 1'b0;
    #1;
    chk("midreset busy",   {31'b0, o_busy},  32'd0);
    chk("midreset valid",  {31'b0, o_valid}, 32'd0);
    chk("midreset stall",  {31'b0, o_stall}, 32'd0);
    chk("midreset result", o_result,         32'd0);
    @(negedge i_Clock);
    @(negedge i_Clock);
    i_Reset = 1'b1;
    nvalid = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge i_Clock);
      if (o_valid) nvalid++;
    end
    chk("midreset no_valid", 32'(nvalid), 32'd0);
    @(posedge i_Clock); #1;
    run_op(3'd0, 32'd7, 32'd6, 32'h2A, 34, "post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Iterative multiply/divide sequencer alongside the EX-stage ALU.
- Accepts one RV32M operation per start pulse, runs a radix-2 shift-add or restoring-divide loop over WIDTH cycles, and returns a registered result.
- Holds the pipeline with o_stall until the result is ready.
- A branch/jump flush aborts an operation in flight.

Parameters:
- WIDTH, 32, operand and result width in bits; must be 32 for RV32M semantics.

Ports:
- i_Clock  input  1  clock; all state updates on the rising edge.
- i_Reset  input  1  reset, active-low, asynchronous.
- i_start  input  1  request a new operation; sampled only in IDLE.
- i_op  input  3  operation code. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_dataA  input  WIDTH  rs1 operand (multiplicand or dividend).
- i_dataB  input  WIDTH  rs2 operand (multiplier or divisor).
- i_flush  input  1  abort the current operation and discard its result.
- o_busy  output  1  high in any state other than IDLE.
- o_stall  output  1  pipeline hold request to the EX stage.
- o_valid  output  1  one-cycle pulse; o_result is valid.
- o_result  output  WIDTH  registered result; holds its value until the next o_valid.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low. i_Clock is the clock and i_Reset is the reset.
- Reset values: state=IDLE, o_busy=0, o_valid=0, o_result=0, counter=0, and all operand/accumulator registers cleared.
- Reset mid-operation:
  - the operation is abandoned immediately;
  - no o_valid is produced;
  - the block accepts a new start one edge after reset releases.
- States are IDLE, CALC, FIXUP, DONE.
- IDLE:
  - On i_start=1 and i_flush=0, latch i_op, i_dataA and i_dataB.
  - For signed ops, take operand magnitudes and record result sign(s).
  - Load counter = WIDTH-1, then go to CALC.
  - Special cases go straight to DONE with the result computed in the same edge:
    - divide by zero (DIV/DIVU/REM/REMU with i_dataB=0);
    - signed overflow (DIV/REM with i_dataA=0x80000000 and i_dataB=0xFFFFFFFF).
- CALC:
  - One iteration per cycle.
  - Multiply: 2*WIDTH-bit product, shift-add on the multiplier LSB.
  - Divide: restoring, one quotient bit per cycle, remainder WIDTH+1 bits.
  - Counter decrements each cycle; when counter=0, go to FIXUP.
- FIXUP:
  - Apply sign correction by two's-complement negation of the product/quotient/remainder as required.
  - Select the output:
    - MUL → low half of the product;
    - MULH, MULHSU and MULHU → high half;
    - DIV/DIVU → quotient;
    - REM/REMU → remainder.
  - Register the selected value into o_result, then go to DONE.
- DONE:
  - o_valid=1 for exactly this cycle; go to IDLE on the next edge.
- Sign rules:
  - MULH: both operands signed.
  - MULHSU: A signed, B unsigned.
  - Remainder takes the sign of the dividend.
  - Quotient is negative iff the operand signs differ.
- Special-case results:
  - Divide by zero: quotient 0xFFFFFFFF; remainder = dividend.
  - Signed overflow: quotient 0x80000000; remainder 0.
- Latency from the i_start edge to the o_valid cycle:
  - normal operation: WIDTH+2 edges (34 for WIDTH=32);
  - special cases: 1 edge.
- o_stall = (state==IDLE && i_start && !i_flush) || state==CALC || state==FIXUP.
  - o_stall is low in DONE so the EX stage captures o_result and advances in that cycle.
- i_start while o_busy=1 is ignored.
- Operands are used only at acceptance; later changes to i_dataA/i_dataB have no effect.
- i_flush=1 in any state: return to IDLE on the next edge, suppress o_valid, and leave o_result unchanged. This includes DONE, where o_valid is still high that cycle because it is already registered.
- i_flush and i_start asserted together in IDLE: flush wins, start is not accepted, o_stall=0.
- Back-to-back operations: the earliest new acceptance is the cycle after DONE, i.e. in IDLE.

Test Plan:
- MUL A=7, B=6, start at cycle 0 → o_stall high cycles 0–33, o_valid at cycle 34, o_result=0x0000002A, o_busy low at cycle 35.
- MULH A=0xFFFFFFFF, B=0xFFFFFFFF → o_result=0x00000000. MULHU with the same operands → 0xFFFFFFFE. MULHSU A=0xFFFFFFFF, B=2 → 0xFFFFFFFF.
- DIV A=0xFFFFFFF9 (-7), B=2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU A=100, B=7 → 14. REMU A=100, B=7 → 2.
- DIVU A=5, B=0 → o_valid one edge after start, result 0xFFFFFFFF. REM A=5, B=0 → 5. DIV A=0x80000000, B=0xFFFFFFFF → 0x80000000. REM with the same operands → 0.
- MUL started, i_flush at cycle 10 → IDLE at cycle 11, no o_valid ever, o_result keeps its previous value. A start at cycle 11 completes normally at cycle 45.
- i_start held high during an entire operation with changing operands → only the first operation runs. i_start+i_flush together in IDLE → nothing accepted, o_stall=0. Reset asserted mid-CALC → all outputs 0 asynchronously, no o_valid.
